// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - control/writeback sequencer around the 2-stage pipelined MUL/IMUL multiplier
module mul_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [1:0]       in_size,
  input  logic [31:0]      in_opa,
  input  logic [31:0]      in_opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic [2:0]       mul_sel,
  output logic [31:0]      mul_opa,
  output logic [31:0]      mul_opb,
  input  logic [63:0]      mul_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_lo,
  output logic [31:0]      out_hi,
  output logic             out_wr_hi,
  output logic             out_cf_of,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   capture;

  logic             op_signed;
  logic [1:0]       op_size;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TAG_W-1:0] op_tag;

  logic [31:0] fmt_lo;
  logic [31:0] fmt_hi;
  logic        fmt_wr_hi;
  logic        fmt_cf_of;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush wins over every other transition, including a DONE handshake.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = flush ? IDLE : WAIT;
      WAIT:    state_nxt = flush ? IDLE : CAPT;
      CAPT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign mul_sel = {op_signed, op_size};
  assign mul_opa = op_a;
  assign mul_opb = op_b;

  // Size 11 falls into the byte default, mirroring the multiplier.
  always_comb begin
    fmt_lo    = {16'b0, mul_res[15:0]};
    fmt_hi    = 32'b0;
    fmt_wr_hi = 1'b0;
    fmt_cf_of = op_signed ? (mul_res[15:8] != {8{mul_res[7]}})
                          : (mul_res[15:8] != 8'h00);
    case (op_size)
      2'b01: begin
        fmt_hi    = {16'b0, mul_res[31:16]};
        fmt_wr_hi = 1'b1;
        fmt_cf_of = op_signed ? (mul_res[31:16] != {16{mul_res[15]}})
                              : (mul_res[31:16] != 16'h0000);
      end
      2'b10: begin
        fmt_lo    = mul_res[31:0];
        fmt_hi    = mul_res[63:32];
        fmt_wr_hi = 1'b1;
        fmt_cf_of = op_signed ? (mul_res[63:32] != {32{mul_res[31]}})
                              : (mul_res[63:32] != 32'h0000_0000);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_signed <= 1'b0;
      op_size   <= 2'b00;
      op_a      <= 32'b0;
      op_b      <= 32'b0;
      op_tag    <= '0;
      out_lo    <= 32'b0;
      out_hi    <= 32'b0;
      out_wr_hi <= 1'b0;
      out_cf_of <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (accept) begin
        op_signed <= in_signed;
        op_size   <= in_size;
        op_a      <= in_opa;
        op_b      <= in_opb;
        op_tag    <= in_tag;
      end
      if (capture) begin
        out_lo    <= fmt_lo;
        out_hi    <= fmt_hi;
        out_wr_hi <= fmt_wr_hi;
        out_cf_of <= fmt_cf_of;
        out_tag   <= op_tag;
      end
    end
  end

endmodule
